// File: rtl/ring_osc_freq_meter.sv
// ring_osc_freq_meter
//   Counts rising edges of the free-running ring oscillator output over a
//   programmable window of clk cycles and reports the result on the pins.
//
// Ports
//   clk       system clock, all state on its rising edge
//   rst_n     asynchronous active-low reset
//   osc_in    ring oscillator output, asynchronous to clk
//   start     measurement request (IDLE and warm-up complete only)
//   gate_len  window length N in clk cycles, latched when start is accepted
//   count     last measured edge count
//   valid     count holds a completed result
//   busy      measurement in progress
//   overflow  last measurement saturated
//
// Handshake: start is a request that is taken only on a cycle where busy=0
// and warm-up is done; anything else is dropped, never queued. valid is a
// level, set when a result lands and cleared by the next accepted start.
// There is no ready on the result side: count is simply held until the
// next result overwrites it.
module ring_osc_freq_meter #(
    parameter int COUNT_W = 16,
    parameter int GATE_W  = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               osc_in,
    input  logic               start,
    input  logic [GATE_W-1:0]  gate_len,
    output logic [COUNT_W-1:0] count,
    output logic               valid,
    output logic               busy,
    output logic               overflow
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ARM  = 2'd1,
        S_GATE = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // Kept as a typed signal so checkers can bind to the FSM state directly.
    state_t state;
    state_t state_nxt;

    logic               sync1;
    logic               sync2;
    logic               hist;
    logic               edge_det;
    logic [2:0]         warm_cnt;
    logic               warm_done;
    logic [GATE_W-1:0]  win_cnt;
    logic [COUNT_W-1:0] edge_cnt;
    logic               ovf_int;

    // Control strobes from the output decode.
    logic               accept;
    logic               do_arm;
    logic               do_gate;
    logic               do_done;

    // Oscillator synchronizer plus history flop; runs continuously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            hist  <= 1'b0;
        end else begin
            sync1 <= osc_in;
            sync2 <= sync1;
            hist  <= sync2;
        end
    end

    assign edge_det = sync2 & ~hist;

    // Warm-up: when osc_in is high at reset release the zeroed flops see a
    // false rising edge; holding off start for 4 cycles lets it flush out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            warm_cnt <= 3'd0;
        end else if (warm_cnt != 3'd4) begin
            warm_cnt <= warm_cnt + 3'd1;
        end
    end

    assign warm_done = (warm_cnt == 3'd4);

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (start && warm_done) state_nxt = S_ARM;
            S_ARM:  state_nxt = (win_cnt == '0) ? S_DONE : S_GATE;
            // win_cnt still holds the remaining count including this cycle.
            S_GATE: if (win_cnt == GATE_W'(1)) state_nxt = S_DONE;
            S_DONE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // FSM output decode.
    always_comb begin
        accept  = 1'b0;
        do_arm  = 1'b0;
        do_gate = 1'b0;
        do_done = 1'b0;
        busy    = 1'b1;
        case (state)
            S_IDLE: begin
                busy   = 1'b0;
                accept = start && warm_done;
            end
            S_ARM:   do_arm  = 1'b1;
            S_GATE:  do_gate = 1'b1;
            S_DONE:  do_done = 1'b1;
            default: busy    = 1'b0;
        endcase
    end

    // Datapath: window counter, edge counter and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_cnt  <= '0;
            edge_cnt <= '0;
            ovf_int  <= 1'b0;
            count    <= '0;
            valid    <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (accept) begin
                win_cnt  <= gate_len;
                valid    <= 1'b0;
                overflow <= 1'b0;
            end
            if (do_arm) begin
                edge_cnt <= '0;
                ovf_int  <= 1'b0;
            end
            if (do_gate) begin
                win_cnt <= win_cnt - GATE_W'(1);
                if (edge_det) begin
                    // Saturate rather than wrap; a lost edge marks overflow.
                    if (edge_cnt == '1) begin
                        ovf_int <= 1'b1;
                    end else begin
                        edge_cnt <= edge_cnt + COUNT_W'(1);
                    end
                end
            end
            if (do_done) begin
                count    <= edge_cnt;
                overflow <= ovf_int;
                valid    <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ring_osc_freq_meter.sv
// Bench for ring_osc_freq_meter, built with a 4-bit edge counter so that
// saturation is reachable in a short run. Expected results are pushed at
// start time; a monitor pops one whenever valid rises.
module tb_ring_osc_freq_meter;

    localparam int CW = 4;
    localparam int GW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          osc_in = 1'b0;
    logic          start = 1'b0;
    logic [GW-1:0] gate_len = '0;
    logic [CW-1:0] count;
    logic          valid;
    logic          busy;
    logic          overflow;

    // Oscillator half period in ns; 0 holds osc_in low.
    int osc_half = 50;

    int checks = 0;
    int errors = 0;

    // Entry: {overflow, count_lo, count_hi}
    logic [2*CW:0] exp_q[$];
    logic          valid_prev = 1'b0;

    ring_osc_freq_meter #(.COUNT_W(CW), .GATE_W(GW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .osc_in   (osc_in),
        .start    (start),
        .gate_len (gate_len),
        .count    (count),
        .valid    (valid),
        .busy     (busy),
        .overflow (overflow)
    );

    // Clock: 10 ns period, rising edges at 5, 15, ...
    always #5 clk = ~clk;

    // Oscillator toggles on a 3 ns offset so it never lands on a clk edge.
    initial begin
        #3;
        forever begin
            if (osc_half == 0) begin
                osc_in = 1'b0;
                #10;
            end else begin
                #(osc_half) osc_in = ~osc_in;
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: compare each newly presented result.
    always @(negedge clk) begin
        logic [2*CW:0] e;
        int lo;
        int hi;
        if (valid && !valid_prev) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_result: count %0d with no expected entry", count);
            end else begin
                e  = exp_q.pop_front();
                lo = int'(e[2*CW-1:CW]);
                hi = int'(e[CW-1:0]);
                if (int'(count) < lo || int'(count) > hi) begin
                    errors++;
                    $display("FAIL result_count: got %0d, expected %0d..%0d", count, lo, hi);
                end
                checks++;
                if (overflow != e[2*CW]) begin
                    errors++;
                    $display("FAIL result_overflow: got %0d, expected %0d", overflow, e[2*CW]);
                end
            end
        end
        valid_prev = valid;
    end

    // Issues start at the next rising edge (call at a negedge), then counts
    // the busy cycles. pulse=1 fires a second start mid-window.
    task automatic run(input int n, input int lo, input int hi, input bit ovf, input bit pulse);
        int cycles;
        gate_len = GW'(n);
        start    = 1'b1;
        exp_q.push_back({ovf, CW'(lo), CW'(hi)});
        @(negedge clk);
        start    = 1'b0;
        gate_len = 16'hFFFF;
        cycles   = 0;
        while (busy && cycles < 2000) begin
            cycles++;
            if (pulse && cycles == 10) begin
                start    = 1'b1;
                gate_len = 16'd5;
            end
            if (pulse && cycles == 11) start = 1'b0;
            @(negedge clk);
        end
        check("busy_cycles", cycles, n + 2);
        check("valid_after_busy", int'(valid), 1);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_count"}, int'(count), 0);
        check({tag, "_valid"}, int'(valid), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_overflow"}, int'(overflow), 0);
    endtask

    initial begin
        // Reset held with the oscillator running.
        repeat (12) @(negedge clk);
        check_zero_outputs("reset");
        rst_n = 1'b1;

        // Warm-up: start held through the first four edges is ignored.
        gate_len = 16'd20;
        start    = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            check($sformatf("warmup_ignore_%0d", i), int'(busy), 0);
        end
        // First accepted run: 20 cycles at period 10 clk -> 2 +/- 1 edges.
        run(20, 1, 3, 1'b0, 1'b0);

        // Nominal: 100 cycles at period 10 clk -> 10 +/- 1 edges.
        run(100, 9, 11, 1'b0, 1'b0);

        // Zero window: result two cycles after start, count 0.
        osc_half = 20;
        run(0, 0, 0, 1'b0, 1'b0);

        // Saturation: 200 cycles at period 4 clk is ~50 edges > 15.
        run(200, 15, 15, 1'b1, 1'b0);
        // Following short run clears overflow: 20/4 = 5 +/- 1.
        run(20, 4, 6, 1'b0, 1'b0);

        // Start pulsed mid-window with a different length is ignored.
        osc_half = 50;
        run(30, 2, 4, 1'b0, 1'b1);

        // Reset halfway through a 100-cycle window.
        gate_len = 16'd100;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (50) @(negedge clk);
        check("pre_reset_busy", int'(busy), 1);
        rst_n = 1'b0;
        #1;
        check_zero_outputs("mid_reset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        run(100, 9, 11, 1'b0, 1'b0);

        repeat (5) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Watchdog against a hung run.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, expected finish before 200000 ns");
        $fatal(1, "watchdog expired");
    end

endmodule
